// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and default
// sizing constants, also used by the frequency calculation block.
package freq_meter_pkg;

    // Reference clock rate; the calculation block uses it to form
    // f = CLK_HZ * cnt_sig / cnt_ref.
    localparam int unsigned CLK_HZ      = 50_000_000;
    // Minimum gate length in clk cycles (1 s preset gate).
    localparam int unsigned GATE_CYC    = 50_000_000;
    // Longest wait for a signal edge before giving up.
    localparam int unsigned TIMEOUT_CYC = 50_000_000;
    // Count width; GATE_CYC + TIMEOUT_CYC must stay below 2**W.
    localparam int unsigned W           = 27;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_MEAS  = 3'd2,
        S_CLOSE = 3'd3,
        S_DONE  = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/freq_gate_counter_sync.sv
// Two-flop synchroniser followed by an edge register, producing a one-cycle
// rising-edge pulse. Usable for any asynchronous single-bit input.
module sig_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchroniser stages plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_out = s2;
    assign rise     = s2 & ~s3;

endmodule

// File: rtl/freq_gate_counter.sv
// Equal-precision gate counter: opens a gate on a signal rising edge, counts
// signal periods and clk cycles until the first rising edge at or after
// GATE_CYC clk cycles, then hands the pair to the calculation block.
//
// state | meaning
// IDLE  | disabled, waiting for en
// ARM   | waiting for the opening edge (timeout runs)
// MEAS  | gate open, minimum gate length not yet reached
// CLOSE | minimum gate reached, waiting for closing edge (timeout runs)
// DONE  | result presented, valid high
module freq_gate_counter #(
    parameter int unsigned GATE_CYC    = freq_meter_pkg::GATE_CYC,
    parameter int unsigned TIMEOUT_CYC = freq_meter_pkg::TIMEOUT_CYC,
    parameter int unsigned W           = freq_meter_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sig_in,
    output logic [W-1:0] cnt_sig,
    output logic [W-1:0] cnt_ref,
    output logic         valid,
    output logic         timeout,
    output logic         busy
);

    import freq_meter_pkg::*;

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_ARM   = S_ARM;
    localparam logic [2:0] ST_MEAS  = S_MEAS;
    localparam logic [2:0] ST_CLOSE = S_CLOSE;
    localparam logic [2:0] ST_DONE  = S_DONE;

    localparam logic [W-1:0] GATE_TC = W'(GATE_CYC);
    localparam logic [W-1:0] TMO_TC  = W'(TIMEOUT_CYC);

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [W-1:0] ref_run;
    logic [W-1:0] ref_nxt;
    logic [W-1:0] sig_run;
    logic [W-1:0] sig_nxt;
    logic [W-1:0] wait_cnt;
    logic [W-1:0] wait_nxt;
    logic [W-1:0] ref_inc;
    logic [W-1:0] wait_inc;
    logic         done_go;
    logic         tmo_go;
    logic         sig_sync;
    logic         sig_rise;

    sig_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sig_in),
        .sync_out (sig_sync),
        .rise     (sig_rise)
    );

    assign ref_inc  = ref_run + W'(1);
    assign wait_inc = wait_cnt + W'(1);

    // Next-state and working-counter updates; done_go/tmo_go mark the edge on
    // which a result (or a timeout) is registered into the outputs.
    always_comb begin
        state_nxt = state;
        ref_nxt   = ref_run;
        sig_nxt   = sig_run;
        wait_nxt  = wait_cnt;
        done_go   = 1'b0;
        tmo_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_ARM;
                    wait_nxt  = '0;
                end
            end
            ST_ARM: begin
                if (sig_rise) begin
                    state_nxt = ST_MEAS;
                    ref_nxt   = '0;
                    sig_nxt   = '0;
                end else if (wait_inc == TMO_TC) begin
                    tmo_go    = 1'b1;
                    state_nxt = ST_ARM;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            ST_MEAS: begin
                ref_nxt = ref_inc;
                if (sig_rise) begin
                    sig_nxt = sig_run + W'(1);
                end
                if (ref_inc == GATE_TC) begin
                    if (sig_rise) begin
                        state_nxt = ST_DONE;
                        done_go   = 1'b1;
                    end else begin
                        state_nxt = ST_CLOSE;
                        wait_nxt  = '0;
                    end
                end
            end
            ST_CLOSE: begin
                ref_nxt = ref_inc;
                if (sig_rise) begin
                    sig_nxt   = sig_run + W'(1);
                    state_nxt = ST_DONE;
                    done_go   = 1'b1;
                end else if (wait_inc == TMO_TC) begin
                    tmo_go    = 1'b1;
                    state_nxt = ST_ARM;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            ST_DONE: begin
                // The closing edge was consumed last cycle, so ARM can only
                // open on a later edge.
                state_nxt = ST_ARM;
                wait_nxt  = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Dropping en abandons whatever is in progress without a result.
        if (!en) begin
            state_nxt = ST_IDLE;
            done_go   = 1'b0;
            tmo_go    = 1'b0;
        end
    end

    // State register and working counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ref_run  <= '0;
            sig_run  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ref_run  <= ref_nxt;
            sig_run  <= sig_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Result registers: loaded on the closing edge so that valid and the new
    // counts are visible together during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sig <= '0;
            cnt_ref <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= done_go | tmo_go;
            if (done_go) begin
                cnt_sig <= sig_nxt;
                cnt_ref <= ref_nxt;
                timeout <= 1'b0;
            end else if (tmo_go) begin
                cnt_sig <= '0;
                cnt_ref <= '0;
                timeout <= 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter with a short gate and timeout. The expected
// results come from the gate rule: for a steady period of P clk, the gate
// holds ceil(GATE/P) periods and the same number of periods times P cycles.
module tb_freq_gate_counter;

    localparam int GATE = 100;
    localparam int TMO  = 200;
    localparam int W    = 27;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         sig_in;
    logic [W-1:0] cnt_sig;
    logic [W-1:0] cnt_ref;
    logic         valid;
    logic         timeout;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Signal generator controls: mode 0 = held low, 1 = periodic, 2 = one pulse.
    int gen_mode  = 0;
    int gen_per   = 10;
    int gen_hi    = 5;
    int gen_epoch = 0;
    int gen_ph    = 0;
    int gen_seen  = 0;

    freq_gate_counter #(
        .GATE_CYC    (GATE),
        .TIMEOUT_CYC (TMO),
        .W           (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sig_in  (sig_in),
        .cnt_sig (cnt_sig),
        .cnt_ref (cnt_ref),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Waveform source, updated on falling clk edges so its period is an exact
    // number of clk cycles.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_seen != gen_epoch) begin
                gen_seen = gen_epoch;
                gen_ph   = 0;
            end
            case (gen_mode)
                1: begin
                    sig_in = (gen_ph < gen_hi);
                    gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
                end
                2: begin
                    sig_in = (gen_ph < 3);
                    if (gen_ph < 3) gen_ph = gen_ph + 1;
                end
                default: sig_in = 1'b0;
            endcase
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of rising clk edges until valid is seen, or -1.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < budget);
        if (!valid) n = -1;
    endtask

    function automatic int periods_in_gate(input int p);
        return (GATE + p - 1) / p;
    endfunction

    // Expects a normal result for a steady signal of period p; optionally also
    // checks the spacing from the previous strobe.
    task automatic meas_check(input string tag, input int p, input bit chk_gap);
        int n;
        int np;
        np = periods_in_gate(p);
        wait_valid(2000, n);
        check({tag, "_arrive"}, (n > 0), 1);
        check({tag, "_cnt_sig"}, cnt_sig, np);
        check({tag, "_cnt_ref"}, cnt_ref, np * p);
        check({tag, "_timeout"}, timeout, 0);
        if (chk_gap) check({tag, "_gap"}, n, (np + 1) * p);
    endtask

    task automatic restart_sig(input int p, input int hi);
        en = 1'b0;
        wait_cyc(3);
        gen_mode  = 1;
        gen_per   = p;
        gen_hi    = hi;
        gen_epoch = gen_epoch + 1;
        wait_cyc(5);
        en = 1'b1;
    endtask

    initial begin
        int n;
        int nv;
        int p;
        int hi;

        rst_n = 1'b0;
        en    = 1'b0;
        #12;
        check("rst_cnt_sig", cnt_sig, 0);
        check("rst_cnt_ref", cnt_ref, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);

        // Period 10: gate closes exactly on the 100th cycle.
        gen_mode = 1;
        gen_per  = 10;
        gen_hi   = 5;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        meas_check("p10_first", 10, 1'b0);
        meas_check("p10_second", 10, 1'b1);

        // Period 7: closing edge arrives through CLOSE.
        restart_sig(7, 3);
        meas_check("p7_first", 7, 1'b0);
        meas_check("p7_second", 7, 1'b1);

        // Drop en mid-gate: busy falls one clk later, no strobe, outputs hold.
        wait_cyc(50);
        en = 1'b0;
        wait_cyc(1);
        check("abort_busy", busy, 0);
        nv = 0;
        for (int i = 0; i < 150; i++) begin
            wait_cyc(1);
            if (valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        check("abort_hold_sig", cnt_sig, 15);
        check("abort_hold_ref", cnt_ref, 105);
        check("abort_hold_tmo", timeout, 0);
        restart_sig(10, 5);
        meas_check("reenable", 10, 1'b0);

        // Asynchronous reset in the middle of a gate.
        wait_cyc(60);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_cnt_sig", cnt_sig, 0);
        check("midrst_cnt_ref", cnt_ref, 0);
        check("midrst_valid", valid, 0);
        check("midrst_timeout", timeout, 0);
        check("midrst_busy", busy, 0);
        wait_cyc(3);
        @(negedge clk);
        rst_n = 1'b1;
        meas_check("after_rst", 10, 1'b0);

        // Randomised steady periods within the valid input range.
        for (int k = 0; k < 6; k++) begin
            p  = $urandom_range(30, 4);
            hi = $urandom_range(p - 2, 2);
            restart_sig(p, hi);
            meas_check($sformatf("rnd%0d_p%0d_a", k, p), p, 1'b0);
            meas_check($sformatf("rnd%0d_p%0d_b", k, p), p, 1'b1);
        end

        // No signal: timeout strobe exactly TMO clk after entering ARM.
        en        = 1'b0;
        gen_mode  = 0;
        gen_epoch = gen_epoch + 1;
        wait_cyc(10);
        en = 1'b1;
        wait_valid(1000, n);
        check("arm_tmo_delay", n, TMO + 1);
        check("arm_tmo_cnt_sig", cnt_sig, 0);
        check("arm_tmo_cnt_ref", cnt_ref, 0);
        check("arm_tmo_flag", timeout, 1);
        check("arm_tmo_busy", busy, 1);
        wait_valid(1000, n);
        check("arm_tmo_repeat", n, TMO);
        check("arm_tmo_flag2", timeout, 1);
        gen_mode  = 1;
        gen_per   = 10;
        gen_hi    = 5;
        gen_epoch = gen_epoch + 1;
        meas_check("tmo_recover", 10, 1'b0);

        // Single pulse then silence: gate reaches CLOSE and times out there.
        gen_mode  = 0;
        gen_epoch = gen_epoch + 1;
        wait_cyc(5);
        gen_mode  = 2;
        gen_epoch = gen_epoch + 1;
        wait_valid(1000, n);
        check("close_tmo_delay", (n >= GATE + TMO && n <= GATE + TMO + 6), 1);
        check("close_tmo_cnt_sig", cnt_sig, 0);
        check("close_tmo_cnt_ref", cnt_ref, 0);
        check("close_tmo_flag", timeout, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
